// File: rtl/fp_div_stream_ctrl.sv
// Result FIFO, first-word-fall-through: a write shows on rd_vld_o the next cycle.
// Writes while full are dropped, so the writer must hold credits; reads need rd_vld_o & rd_rdy_i.
module fp_div_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_vld_o,
  output logic [WIDTH-1:0] rd_dat_o,
  input  logic             rd_rdy_i,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_vld_o = (wr_ptr_q != rd_ptr_q);
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en    = wr_vld_i & ~full_o;
  assign rd_en    = rd_vld_o & rd_rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end
endmodule

// Feeds a non-stallable divider with num/denom pairs under credit control and replays
// results in order on q_*; issue-to-q_valid is LATENCY+1, q_ready backpressure throttles issue.
module fp_div_stream_ctrl #(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 28,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WIDTH-1:0] denom_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [WIDTH-1:0] num_data_i,
  input  logic             num_valid_i,
  output logic             num_ready_o,
  output logic [WIDTH-1:0] div_a_o,
  output logic [WIDTH-1:0] div_b_o,
  output logic             div_ready_o,
  input  logic [WIDTH-1:0] div_o_i,
  input  logic             div_valid_i,
  output logic [WIDTH-1:0] q_data_o,
  output logic             q_valid_o,
  input  logic             q_ready_i,
  output logic             q_last_o
);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic [WIDTH-1:0]   denom_q, denom_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic               done_q, done_d;
  logic               issue, pop, fifo_wr, fifo_full, last_issue, last_pop, at_last;
  logic [LATENCY-1:0] pend_q;

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign num_ready_o = (state_q == RUN) && (credits_q != '0) && (issued_q < len_q);
  assign issue       = num_valid_i & num_ready_o;
  assign div_a_o     = num_data_i;
  assign div_b_o     = denom_q;
  assign div_ready_o = issue;
  // Results arriving while IDLE belong to an aborted job and are dropped.
  assign fifo_wr     = div_valid_i & busy_o;
  assign pop         = q_valid_o & q_ready_i;
  assign at_last     = (popped_q == len_q - LEN_W'(1));
  assign q_last_o    = q_valid_o & at_last;
  assign last_issue  = issue && (issued_q == len_q - LEN_W'(1));
  assign last_pop    = pop & at_last;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    denom_d   = denom_q;
    issued_d  = issued_q;
    popped_d  = popped_q;
    credits_d = credits_q;
    done_d    = 1'b0;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
    if (issue) issued_d = issued_q + LEN_W'(1);
    if (pop)   popped_d = popped_q + LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = RUN;
            len_d     = len_i;
            denom_d   = denom_i;
            issued_d  = '0;
            popped_d  = '0;
            credits_d = CRED_W'(FIFO_DEPTH);
          end
        end
      end
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      denom_q   <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      credits_q <= CRED_W'(FIFO_DEPTH);
      done_q    <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      denom_q   <= denom_d;
      issued_q  <= issued_d;
      popped_q  <= popped_d;
      credits_q <= credits_d;
      done_q    <= done_d;
      pend_q    <= (pend_q << 1) | LATENCY'(issue);
    end
  end

  fp_div_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wr_vld_i (fifo_wr),
    .wr_dat_i (div_o_i),
    .rd_vld_o (q_valid_o),
    .rd_dat_o (q_data_o),
    .rd_rdy_i (q_ready_i),
    .full_o   (fifo_full)
  );

  // pend_q tracks which issues are due back, catching a divider whose latency differs.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(fifo_wr && fifo_full));
  a_on_time:     assert property (@(posedge clk_i) disable iff (!rst_n_i) fifo_wr |-> pend_q[LATENCY-1]);
  a_credit_max:  assert property (@(posedge clk_i) disable iff (!rst_n_i) credits_q <= CRED_W'(FIFO_DEPTH));
endmodule

// File: doc/fp_div_stream_ctrl.md
# fp_div_stream_ctrl

Streaming controller that sits directly upstream and downstream of the pipelined floating-point divider. It divides a vector of `len` numerators by one latched scalar denominator, as in the LCMV weight normalisation step. It issues operands to the divider and captures the fixed-latency results into an internal FIFO. It presents the quotients on a valid/ready output stream and uses credit-based flow control, because the divider itself cannot be stalled.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (IEEE-754 single).
- `LATENCY`, 28, divider latency in cycles, from issue to `div_valid`.
- `FIFO_DEPTH`, 32, result FIFO entries; power of 2, ≥2. Full throughput requires ≥ `LATENCY`+1.
- `MAX_LEN`, 256, maximum vector length; `LEN_W` = $clog2(`MAX_LEN`+1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low. Single clock domain.
- `start` in 1: begin a job; sampled only in IDLE.
- `len` in `LEN_W`: element count, latched on `start`.
- `denom` in `WIDTH`: denominator, latched on `start`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle completion pulse.
- `num_data` in `WIDTH`: numerator stream data.
- `num_valid` in 1: numerator stream valid.
- `num_ready` out 1: numerator stream ready.
- `div_a` out `WIDTH`: divider dividend; equals `num_data`.
- `div_b` out `WIDTH`: divider divisor; the latched denominator.
- `div_ready` out 1: divider input strobe, equal to `num_valid & num_ready`.
- `div_o` in `WIDTH`: divider result.
- `div_valid` in 1: divider result strobe.
- `q_data` out `WIDTH`: quotient stream data.
- `q_valid` out 1: quotient stream valid.
- `q_ready` in 1: quotient stream ready.
- `q_last` out 1: marks the `len`-th quotient.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- **IDLE, `start`=1, `len`>0:** latch `len` and `denom`, clear the `issued` and `popped` counters, go to RUN.
- **IDLE, `start`=1, `len`=0:** stay in IDLE and pulse `done` the next cycle. No divider activity.
- **`start` while busy:** ignored; the latched values do not change.
- **RUN issue rule:**
  - `num_ready` = (state==RUN) & (`credits`>0) & (`issued`<`len`).
  - `num_ready` is combinational from registered state, with no dependence on `num_valid`.
  - On a handshake, `issued`++ and `credits`--.
- **RUN → DRAIN:** on the cycle `issued` reaches `len`.
- **Credits:**
  - `credits` = `FIFO_DEPTH` − (FIFO occupancy + divider in-flight).
  - Reset/start value is `FIFO_DEPTH`.
  - Issue decrements, pop increments, and simultaneous issue+pop leaves it unchanged.
  - Never exceeds `FIFO_DEPTH` and never goes below 0.
- **Capture:**
  - Every `div_valid` while busy writes `div_o` into the FIFO.
  - `div_valid` while IDLE is dropped.
  - `div_valid` with the FIFO full is an assertion failure; credits make it unreachable.
- **Output FIFO:**
  - First-word-fall-through.
  - A pop happens on `q_valid & q_ready`, with `popped`++.
  - `q_last` = `q_valid` & (`popped` == `len`−1).
- **DRAIN → IDLE:** when the pop brings `popped` to `len`; register a `done` pulse on the next cycle.
- **Ordering:** quotients leave in issue order; there is no reordering.
- **Arithmetic:** none inside this block. Data passes through unmodified, and NaN/Inf/zero results are forwarded as produced.

## Timing
- **Reset values:**
  - `num_ready`, `div_ready`, `q_valid`, `q_last`, `busy`, `done` = 0.
  - `div_b` = 0; FIFO empty; counters 0; credits = `FIFO_DEPTH`; state IDLE.
- **Reset mid-job:** all of the above apply on the cycle after `rst_n` is sampled low. In-flight divider results are discarded; the divider shares the same reset, inverted at top level.
- **Latency:** issue at cycle t → `div_valid` at t+`LATENCY` → FIFO write at that edge → `q_valid` at t+`LATENCY`+1.
- **Throughput:** one element per cycle sustained when `num_valid`=`q_ready`=1 and `FIFO_DEPTH` ≥ `LATENCY`+1.
- **Output stream rules:** `q_data`/`q_last` hold stable while `q_valid` & !`q_ready`. `q_valid` does not depend combinationally on `q_ready`.
- **`done` timing:** asserted exactly one cycle, the cycle after the last pop. `busy` falls in the same cycle `done` rises.
- **Start after `done`:** a new `start` is accepted in the same cycle as `done`.

## Test plan
- **Basic job:**
  - Stimulus: `len`=4, `denom`=0x40000000 (2.0); nums 0x3F800000, 0x40000000, 0x40400000, 0x40800000; `q_ready`=1.
  - Response: `q_data` = 0x3F000000, 0x3F800000, 0x3FC00000, 0x40000000; `q_last` only on the 4th; `done` one cycle after the 4th pop.
- **Full throughput:**
  - Stimulus: `len`=100, `num_valid`=`q_ready`=1 throughout.
  - Response: first `q_valid` 29 cycles after the first issue, then 100 contiguous beats; `num_ready` never drops before 100 issues.
- **Backpressure:**
  - Stimulus: `len`=64, `q_ready`=0.
  - Response: exactly 32 issues, then `num_ready`=0 and the FIFO holds 32. Raising `q_ready` delivers all 64 in order, with no `div_valid` while the FIFO is full.
- **Zero length:**
  - Stimulus: `start` with `len`=0.
  - Response: `done` the next cycle; `busy`, `div_ready`, `q_valid` stay 0.
- **Reset mid-job:**
  - Stimulus: `len`=50, `rst_n` low after 10 issues; then `start` with `len`=3.
  - Response: all outputs at reset values the next cycle; exactly 3 quotients and one `done`, with no stale results.
- **Start while busy:**
  - Stimulus: second `start` with `len`=7, `denom`=1.0 during RUN.
  - Response: ignored; the original `len`/`denom` are used; `done` pulses once.
